mem_serialiser_param: RTL and testbench
=======================================

Name: mem_serialiser_param

Overview:
- Parametrised successor to the bit-serial load/store serialiser in the bit-serial core.
- Accepts a serial byte address and a load/store request, then moves data between a parallel memory word and the serial register datapath, DIGIT bits per cycle.
- Adds over the previous generation:
  - configurable XLEN and DIGIT;
  - an internal digit counter, so no external bit position;
  - a start/done handshake;
  - an explicit memory read cycle;
  - byte enables on stores;
  - LWU/LD/SD support when XLEN=64;
  - illegal-op reporting.

Parameters:
- XLEN, 32: data width; legal values 32 or 64.
- ADDR_W, 12: serial byte-address width; must be a multiple of DIGIT.
- DIGIT, 1: bits transferred per cycle; legal values 1, 2, 4; must divide XLEN.
- Derived, not overridable:
  - WL = log2(XLEN/8);
  - MA_W = ADDR_W-WL;
  - A = ADDR_W/DIGIT;
  - T = XLEN/DIGIT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- store  in  1  1=store, 0=load; latched with start.
- func  in  3  RISC-V funct3; latched with start.
- addr_in  in  DIGIT  serial byte address, least-significant digit first.
- data_in  in  DIGIT  serial store data, LS digit first.
- data_out  out  DIGIT  serial load result, LS digit first.
- mem_rdata  in  XLEN  memory read word.
- mem_addr  out  MA_W  word address.
- mem_wdata  out  XLEN  lane-aligned store data.
- mem_be  out  XLEN/8  byte enables.
- mem_we  out  1  write strobe, one cycle.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  valid with done.
- illegal  out  1  valid with done.

Behaviour:
- Reset: state=IDLE. All outputs are 0: data_out, mem_addr, mem_wdata, mem_be, mem_we, busy, done, misaligned, illegal.
- Reset in any state aborts the transfer. No mem_we is issued and no done pulse is produced.
- States: IDLE, ADDR, RD, XFER, DONE. The counter is cnt, width clog2(max(A,T)).
- IDLE:
  - start=1 latches store/func, clears cnt, goes to ADDR.
  - start is ignored while busy.
- ADDR:
  - Each cycle shifts addr_in into the address register at digit position cnt, for A cycles.
  - On the last digit, legality and alignment are evaluated from the completed address.
  - Any fault → DONE with no memory access.
  - Otherwise a load goes to RD and a store goes to XFER.
- Access size from func[1:0]: 00=byte, 01=half, 10=word, 11=dword.
- Illegal combinations:
  - func=111 for any op;
  - dword or func=110 when XLEN=32;
  - store with func[2]=1.
- Misaligned: byte address not a multiple of the access size. Illegal takes priority, so at most one fault flag is set.
- mem_addr = address[ADDR_W-1:WL]. Driven from RD/XFER entry until IDLE; held otherwise.
- RD, loads only, one cycle:
  - mem_addr is presented;
  - at the end of the cycle, mem_rdata is captured;
  - the addressed field is right-shifted to bit 0 by (address[WL-1:0]*8);
  - the field is sign-extended when func[2]=0 and zero-extended when func[2]=1.
- XFER, T cycles:
  - Load: data_out = result digit cnt, bits [cnt*DIGIT +: DIGIT], driven combinationally in cycle cnt.
  - Store: data_in is captured into digit cnt of the store register.
  - data_out is 0 outside XFER.
- DONE, one cycle:
  - done=1 and busy=1;
  - misaligned and illegal are valid;
  - then go to IDLE.
- Store with no fault, in DONE:
  - mem_we=1;
  - mem_wdata = store register truncated to the access size, shifted to its byte lane; other bytes are 0;
  - mem_be = size mask << byte offset.
- Latency from the start cycle to done:
  - load: A+T+2 cycles;
  - store: A+T+1 cycles;
  - fault: A+1 cycles.
- start asserted in the DONE cycle is ignored. A new request needs start in IDLE.

Decomposition:
- Package mem_ser_pkg holds:
  - funct3 constants F_B, F_H, F_W, F_D, F_BU, F_HU, F_WU;
  - the state enum;
  - the size-mask function;
  - the sign/zero-extend function.
- One sub-module, digit_shift_reg (params WIDTH, DIGIT):
  - load-parallel, capture-digit-at-index, read-digit-at-index;
  - instanced for the address register, the load result and the store register.

Test Plan:
- XLEN=32, DIGIT=1, LB at addresses 0..3 with mem_rdata=FF<<8i → serial result FFFFFFFF; mem_addr=0; done at cycle A+T+2=46.
- LBU/LHU at address 5/6 with mem_rdata=0x70060076 → LBU at 5 gives 00000000; LHU at 6 gives 00007006; mem_addr=1.
- SB 0x76 at address 7 → mem_we pulse once; mem_wdata=76000000; mem_be=1000; done at cycle 45.
- Faults, each → done at cycle A+1=13; no mem_we; flag set:
  - LH at address 3 → misaligned=1;
  - SW at address 2 → misaligned=1;
  - LD with XLEN=32 → illegal=1, misaligned=0.
- XLEN=64, DIGIT=4, LWU at address 12 with mem_rdata=8006000000000000 (upper word 80060000 at address 12) → 0000000080060000; LW → FFFFFFFF80060000.
- Reset asserted mid-XFER of an SW → busy=0 next cycle; mem_we is never asserted; a fresh LW afterwards completes correctly.

Source files
------------

// File: rtl/mem_ser_pkg.sv
// Shared definitions for the parametrised bit-serial load/store serialiser.
//   - RISC-V funct3 encodings for loads and stores
//   - controller state encoding
//   - access-size helpers: byte-lane mask and sign/zero extension
package mem_ser_pkg;

  // funct3 encodings. 3'b111 has no meaning and is always rejected.
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_D  = 3'b011;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;
  localparam logic [2:0] F_WU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RD,
    ST_XFER,
    ST_DONE
  } state_t;

  // Byte-lane mask for an access size (func[1:0]), before it is shifted
  // to its byte offset. Callers narrower than 64 bits truncate the result.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    unique case (size)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Keep the low field of the given access size and extend it to 64 bits.
  // zero_ext is func[2]: 1 for the unsigned load variants.
  function automatic logic [63:0] extend_field(input logic [63:0] raw,
                                               input logic [1:0]  size,
                                               input logic        zero_ext);
    logic [63:0] v;
    unique case (size)
      2'b00:   v = zero_ext ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'b01:   v = zero_ext ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10:   v = zero_ext ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: v = raw;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mem_serialiser_param_digit_shift_reg.sv
// digit_shift_reg: WIDTH-bit register addressed as WIDTH/DIGIT digits.
//   load / load_data   : parallel load of the whole word (wins over capture)
//   capture / wr_idx / din : overwrite digit wr_idx with din
//   rd_idx / dout      : combinational read of digit rd_idx
//   q                  : current contents
//   q_next             : value q takes at the next edge (lets the owner act on
//                        a word whose final digit is arriving this cycle)
// clk, reset: rising-edge clock, synchronous active-high clear.
module digit_shift_reg #(
  parameter  int WIDTH = 32,
  parameter  int DIGIT = 1,
  localparam int NDIG  = WIDTH / DIGIT,
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             capture,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [DIGIT-1:0] din,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [DIGIT-1:0] dout,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_next = q;
    if (load) begin
      q_next = load_data;
    end else if (capture) begin
      for (int i = 0; i < NDIG; i++) begin
        if (wr_idx == IDX_W'(i)) q_next[i*DIGIT +: DIGIT] = din;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= q_next;
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (rd_idx == IDX_W'(i)) dout = q[i*DIGIT +: DIGIT];
    end
  end

endmodule

// File: rtl/mem_serialiser_param.sv
// mem_serialiser_param: moves data between a parallel memory word and a
// serial register datapath, DIGIT bits per cycle, LS digit first.
// Sequence: IDLE -> ADDR (A cycles, serial byte address) -> [RD (loads,
// one cycle)] -> XFER (T cycles of serial data) -> DONE (one cycle) -> IDLE.
// A faulting request skips straight from ADDR to DONE with no memory access.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, store, func  request strobe (IDLE only) with op and funct3
//   addr_in             serial byte address digit
//   data_in / data_out  serial store data / serial load result
//   mem_rdata           memory read word, captured at the end of RD
//   mem_addr            word address, updated on entry to RD/XFER
//   mem_wdata, mem_be   lane-aligned store data and byte enables (DONE)
//   mem_we              one-cycle write strobe in DONE
//   busy, done          not-idle flag, one-cycle completion pulse
//   misaligned, illegal fault flags, valid with done
module mem_serialiser_param
  import mem_ser_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int ADDR_W  = 12,
  parameter  int DIGIT   = 1,
  localparam int NB      = XLEN / 8,
  localparam int WL      = $clog2(NB),
  localparam int MA_W    = ADDR_W - WL,
  localparam int A       = ADDR_W / DIGIT,
  localparam int T       = XLEN / DIGIT,
  localparam int MAX_AT  = (A > T) ? A : T,
  localparam int CNT_W   = (MAX_AT > 1) ? $clog2(MAX_AT) : 1,
  localparam int A_IDX_W = (A > 1) ? $clog2(A) : 1,
  localparam int T_IDX_W = (T > 1) ? $clog2(T) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             store,
  input  logic [2:0]       func,
  input  logic [DIGIT-1:0] addr_in,
  input  logic [DIGIT-1:0] data_in,
  output logic [DIGIT-1:0] data_out,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic [MA_W-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [NB-1:0]    mem_be,
  output logic             mem_we,
  output logic             busy,
  output logic             done,
  output logic             misaligned,
  output logic             illegal
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q;
  logic [2:0]        func_q;
  logic              ill_q, mis_q;
  logic [MA_W-1:0]   mem_addr_q;

  logic              addr_last, xfer_last;
  logic [ADDR_W-1:0] addr_q, addr_full;
  logic [WL-1:0]     byte_off;
  logic              illegal_c, misaligned_c, fault_c;
  logic [2:0]        align_mask;
  logic [XLEN-1:0]   load_word, store_word;
  logic [DIGIT-1:0]  load_digit;
  logic [NB-1:0]     lane_mask;
  logic [XLEN-1:0]   lane_bits;

  // Register outputs that this block has no use for.
  logic [DIGIT-1:0]  unused_addr_digit, unused_store_digit;
  logic [XLEN-1:0]   unused_res_q, unused_res_next, unused_store_next;
  logic [MA_W-1:0]   unused_addr_hi;

  assign addr_last = (cnt_q == CNT_W'(A - 1));
  assign xfer_last = (cnt_q == CNT_W'(T - 1));

  // ---------------------------------------------------------------------
  // Serial registers
  // ---------------------------------------------------------------------
  digit_shift_reg #(.WIDTH(ADDR_W), .DIGIT(DIGIT)) u_addr_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ('0),
    .capture   (state_q == ST_ADDR),
    .wr_idx    (cnt_q[A_IDX_W-1:0]),
    .din       (addr_in),
    .rd_idx    ('0),
    .dout      (unused_addr_digit),
    .q         (addr_q),
    .q_next    (addr_full)
  );

  digit_shift_reg #(.WIDTH(XLEN), .DIGIT(DIGIT)) u_load_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (state_q == ST_RD),
    .load_data (load_word),
    .capture   (1'b0),
    .wr_idx    ('0),
    .din       ('0),
    .rd_idx    (cnt_q[T_IDX_W-1:0]),
    .dout      (load_digit),
    .q         (unused_res_q),
    .q_next    (unused_res_next)
  );

  digit_shift_reg #(.WIDTH(XLEN), .DIGIT(DIGIT)) u_store_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ('0),
    .capture   (state_q == ST_XFER && store_q),
    .wr_idx    (cnt_q[T_IDX_W-1:0]),
    .din       (data_in),
    .rd_idx    ('0),
    .dout      (unused_store_digit),
    .q         (store_word),
    .q_next    (unused_store_next)
  );

  // Byte offset within the word; only the word address leaves the block.
  assign byte_off       = addr_q[WL-1:0];
  assign unused_addr_hi = addr_q[ADDR_W-1:WL];

  // ---------------------------------------------------------------------
  // Legality and alignment, judged on the address including the digit
  // that arrives in the last ADDR cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    illegal_c = (func_q == 3'b111) || (store_q && func_q[2]);
    if (XLEN == 32 && (func_q[1:0] == 2'b11 || func_q == F_WU)) illegal_c = 1'b1;
    // Low address bits that must be zero for the access size.
    align_mask   = 3'((4'd1 << func_q[1:0]) - 4'd1);
    misaligned_c = |(addr_full[2:0] & align_mask);
    fault_c      = illegal_c || misaligned_c;
  end

  // Loaded field moved down to bit 0, then sign- or zero-extended.
  assign load_word = XLEN'(extend_field(64'(mem_rdata >> {byte_off, 3'b000}),
                                        func_q[1:0], func_q[2]));

  // Store lanes: truncate to the access size, then move to the byte offset.
  always_comb begin
    lane_mask = NB'(size_mask(func_q[1:0]));
    lane_bits = '0;
    for (int b = 0; b < NB; b++) lane_bits[b*8 +: 8] = {8{lane_mask[b]}};
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADDR;
          cnt_d   = '0;
        end
      end
      ST_ADDR: begin
        if (addr_last) begin
          cnt_d = '0;
          if (fault_c)      state_d = ST_DONE;
          else if (store_q) state_d = ST_XFER;
          else              state_d = ST_RD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RD: state_d = ST_XFER;
      ST_XFER: begin
        if (xfer_last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request attributes, fault flags and the held word address.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_q    <= 1'b0;
      func_q     <= '0;
      ill_q      <= 1'b0;
      mis_q      <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        store_q <= store;
        func_q  <= func;
        ill_q   <= 1'b0;
        mis_q   <= 1'b0;
      end
      if (state_q == ST_ADDR && addr_last) begin
        ill_q <= illegal_c;
        mis_q <= misaligned_c && !illegal_c;
        if (!fault_c) mem_addr_q <= addr_full[ADDR_W-1:WL];
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    misaligned = done && mis_q;
    illegal    = done && ill_q;
    mem_addr   = mem_addr_q;
    data_out   = (state_q == ST_XFER && !store_q) ? load_digit : '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    mem_be     = '0;
    if (state_q == ST_DONE && store_q && !ill_q && !mis_q) begin
      mem_we    = 1'b1;
      mem_wdata = (store_word & lane_bits) << {byte_off, 3'b000};
      mem_be    = lane_mask << byte_off;
    end
  end

endmodule

// File: tb/tb_mem_serialiser_param.sv
// Bench for mem_serialiser_param: one XLEN=32/DIGIT=1 instance and one
// XLEN=64/DIGIT=4 instance sharing clock and reset. A driver task runs one
// request through the selected instance and records what it observed;
// each test task compares those observations with a byte-level model.
module tb_mem_serialiser_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      = 1'b1;
  logic        sel_wide   = 1'b0;
  logic        start_c    = 1'b0;
  logic        store_c    = 1'b0;
  logic [2:0]  func_c     = '0;
  logic [3:0]  addr_digit = '0;
  logic [3:0]  din_digit  = '0;
  logic [63:0] rdata_c    = '0;

  logic        dout32;
  logic [9:0]  maddr32;
  logic [31:0] wdata32;
  logic [3:0]  be32;
  logic        we32, busy32, done32, mis32, ill32;

  logic [3:0]  dout64;
  logic [8:0]  maddr64;
  logic [63:0] wdata64;
  logic [7:0]  be64;
  logic        we64, busy64, done64, mis64, ill64;

  mem_serialiser_param #(.XLEN(32), .ADDR_W(12), .DIGIT(1)) dut32 (
    .clk(clk), .reset(reset), .start(start_c & ~sel_wide), .store(store_c),
    .func(func_c), .addr_in(addr_digit[0]), .data_in(din_digit[0]),
    .data_out(dout32), .mem_rdata(rdata_c[31:0]), .mem_addr(maddr32),
    .mem_wdata(wdata32), .mem_be(be32), .mem_we(we32), .busy(busy32),
    .done(done32), .misaligned(mis32), .illegal(ill32)
  );

  mem_serialiser_param #(.XLEN(64), .ADDR_W(12), .DIGIT(4)) dut64 (
    .clk(clk), .reset(reset), .start(start_c & sel_wide), .store(store_c),
    .func(func_c), .addr_in(addr_digit), .data_in(din_digit),
    .data_out(dout64), .mem_rdata(rdata_c), .mem_addr(maddr64),
    .mem_wdata(wdata64), .mem_be(be64), .mem_we(we64), .busy(busy64),
    .done(done64), .misaligned(mis64), .illegal(ill64)
  );

  // Observed signals of whichever instance is selected.
  logic [3:0]  obs_dout;
  logic [11:0] obs_maddr;
  logic [63:0] obs_wdata;
  logic [7:0]  obs_be;
  logic        obs_we, obs_busy, obs_done, obs_mis, obs_ill;

  always_comb begin
    if (sel_wide) begin
      obs_dout = dout64; obs_maddr = {3'b0, maddr64}; obs_wdata = wdata64;
      obs_be = be64; obs_we = we64; obs_busy = busy64; obs_done = done64;
      obs_mis = mis64; obs_ill = ill64;
    end else begin
      obs_dout = {3'b0, dout32}; obs_maddr = {2'b0, maddr32};
      obs_wdata = {32'b0, wdata32}; obs_be = {4'b0, be32}; obs_we = we32;
      obs_busy = busy32; obs_done = done32; obs_mis = mis32; obs_ill = ill32;
    end
  end

  typedef struct {
    int          done_cyc;   // cycle of the done pulse, start cycle = 0; -1 if none
    logic [63:0] result;     // serial load result assembled from data_out
    int          we_cnt;
    int          we_cyc;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        mis;
    logic        ill;
    logic [11:0] maddr;      // mem_addr seen in the done cycle
    int          stray;      // cycles with nonzero data_out outside the load window
    logic        busy_after; // busy one cycle after done (or after an abort)
  } obs_t;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  function automatic void ref_fault(input int xlen, input bit st, input logic [2:0] fn,
                                    input logic [11:0] addr, output bit ill, output bit mis);
    int nbytes;
    nbytes = 1 << fn[1:0];
    ill = (fn == 3'd7) || (st && fn[2]) || (xlen == 32 && (fn[1:0] == 2'd3 || fn == 3'd6));
    mis = !ill && ((int'(addr) % nbytes) != 0);
  endfunction

  function automatic logic [63:0] ref_load(input int xlen, input logic [2:0] fn,
                                           input logic [11:0] addr, input logic [63:0] rdata);
    int nbytes, off;
    logic [63:0] v;
    nbytes = 1 << fn[1:0];
    off    = int'(addr) % (xlen / 8);
    v      = rdata >> (off * 8);
    for (int b = nbytes * 8; b < 64; b++) v[b] = fn[2] ? 1'b0 : v[nbytes*8-1];
    if (xlen == 32) v[63:32] = '0;
    return v;
  endfunction

  function automatic void ref_store(input int xlen, input logic [2:0] fn, input logic [11:0] addr,
                                    input logic [63:0] sdata,
                                    output logic [63:0] wdata, output logic [7:0] be);
    int nbytes, off;
    nbytes = 1 << fn[1:0];
    off    = int'(addr) % (xlen / 8);
    wdata  = '0;
    be     = '0;
    for (int k = 0; k < nbytes; k++) begin
      wdata[(off+k)*8 +: 8] = sdata[k*8 +: 8];
      be[off+k] = 1'b1;
    end
  endfunction

  // ---------------------------------------------------------------------
  // Driver: one request on the selected instance. abort_cyc > 0 pulses
  // reset in that cycle; keep_start holds start high until done is seen.
  // ---------------------------------------------------------------------
  task automatic drive_op(input bit wide, input bit st, input logic [2:0] fn,
                          input logic [11:0] addr, input logic [63:0] sdata,
                          input logic [63:0] rdata, input int abort_cyc,
                          input bit keep_start, output obs_t o);
    int dg, a_n, t_n, cyc, limit;
    bit done_seen;
    logic [3:0] dmask;
    dg    = wide ? 4 : 1;
    a_n   = 12 / dg;
    t_n   = (wide ? 64 : 32) / dg;
    dmask = 4'((1 << dg) - 1);
    limit = a_n + t_n + 8 + abort_cyc;
    o = '{done_cyc: -1, result: '0, we_cnt: 0, we_cyc: -1, wdata: '0, be: '0,
          mis: 1'b0, ill: 1'b0, maddr: '0, stray: 0, busy_after: 1'b1};
    done_seen = 1'b0;
    sel_wide  = wide;
    rdata_c   = rdata;
    @(posedge clk); #1;
    cyc = 0;
    forever begin
      start_c = (cyc == 0) || (keep_start && !done_seen);
      store_c = (cyc == 0) ? st : 1'($urandom);
      func_c  = (cyc == 0) ? fn : 3'($urandom);
      reset   = (abort_cyc > 0 && cyc == abort_cyc);
      if (cyc >= 1 && cyc <= a_n) addr_digit = 4'(64'(addr) >> ((cyc - 1) * dg)) & dmask;
      else                        addr_digit = 4'($urandom);
      if (st && cyc >= a_n + 1 && cyc <= a_n + t_n) din_digit = 4'(sdata >> ((cyc - a_n - 1) * dg)) & dmask;
      else                                          din_digit = 4'($urandom);
      @(negedge clk);
      if (obs_done && !done_seen) begin
        done_seen  = 1'b1;
        o.done_cyc = cyc;
        o.mis      = obs_mis;
        o.ill      = obs_ill;
        o.maddr    = obs_maddr;
      end
      if (obs_we) begin
        o.we_cnt++;
        o.we_cyc = cyc;
        o.wdata  = obs_wdata;
        o.be     = obs_be;
      end
      if (!st && cyc >= a_n + 2 && cyc <= a_n + t_n + 1)
        o.result = o.result | (64'(obs_dout & dmask) << ((cyc - a_n - 2) * dg));
      else if (obs_dout != 4'd0)
        o.stray++;
      if (abort_cyc > 0 && cyc == abort_cyc + 1) o.busy_after = obs_busy;
      if (abort_cyc == 0 && done_seen && cyc == o.done_cyc + 1) begin
        o.busy_after = obs_busy;
        break;
      end
      if (cyc >= limit) break;
      @(posedge clk); #1;
      cyc++;
    end
    start_c = 1'b0;
    reset   = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dout32, maddr32, wdata32, be32, we32, busy32, done32, mis32, ill32} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_x32 got %h want 0",
               {dout32, maddr32, wdata32, be32, we32, busy32, done32, mis32, ill32});
    end
    checks++;
    if ({dout64, maddr64, wdata64, be64, we64, busy64, done64, mis64, ill64} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_x64 got %h want 0",
               {dout64, maddr64, wdata64, be64, we64, busy64, done64, mis64, ill64});
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_lb_lanes();
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      drive_op(1'b0, 1'b0, 3'b000, 12'(i), '0, 64'(32'hFF << (8 * i)), 0, 1'b0, o);
      checks++;
      if (o.result !== 64'h0000_0000_FFFF_FFFF) begin
        errors++; $display("FAIL lb_result addr=%0d got %h want 00000000ffffffff", i, o.result);
      end
      checks++;
      if (o.done_cyc != 46) begin
        errors++; $display("FAIL lb_latency addr=%0d got %0d want 46", i, o.done_cyc);
      end
      checks++;
      if (o.maddr !== 12'd0) begin
        errors++; $display("FAIL lb_mem_addr addr=%0d got %0d want 0", i, o.maddr);
      end
    end
  endtask

  task automatic test_unsigned_loads();
    obs_t o;
    drive_op(1'b0, 1'b0, 3'b100, 12'd5, '0, 64'h7006_0076, 0, 1'b0, o);
    checks++;
    if (o.result !== 64'h0) begin
      errors++; $display("FAIL lbu_result got %h want 0", o.result);
    end
    checks++;
    if (o.maddr !== 12'd1) begin
      errors++; $display("FAIL lbu_mem_addr got %0d want 1", o.maddr);
    end
    drive_op(1'b0, 1'b0, 3'b101, 12'd6, '0, 64'h7006_0076, 0, 1'b0, o);
    checks++;
    if (o.result !== 64'h7006) begin
      errors++; $display("FAIL lhu_result got %h want 7006", o.result);
    end
    checks++;
    if (o.maddr !== 12'd1) begin
      errors++; $display("FAIL lhu_mem_addr got %0d want 1", o.maddr);
    end
  endtask

  task automatic test_store_byte();
    obs_t o;
    logic [63:0] sdata;
    sdata = {32'h0, 24'($urandom), 8'h76};
    drive_op(1'b0, 1'b1, 3'b000, 12'd7, sdata, '0, 0, 1'b0, o);
    checks++;
    if (o.we_cnt != 1 || o.we_cyc != 45) begin
      errors++; $display("FAIL sb_we got count=%0d cycle=%0d want count=1 cycle=45", o.we_cnt, o.we_cyc);
    end
    checks++;
    if (o.wdata !== 64'h7600_0000 || o.be !== 8'b1000) begin
      errors++; $display("FAIL sb_lane got wdata=%h be=%b want 76000000 be=1000", o.wdata, o.be);
    end
    checks++;
    if (o.done_cyc != 45) begin
      errors++; $display("FAIL sb_latency got %0d want 45", o.done_cyc);
    end
  endtask

  task automatic test_faults();
    obs_t o;
    logic [2:0]  fns[3]   = '{3'b001, 3'b010, 3'b011};
    bit          sts[3]   = '{1'b0, 1'b1, 1'b0};
    logic [11:0] addrs[3] = '{12'd3, 12'd2, 12'd0};
    bit          emis[3]  = '{1'b1, 1'b1, 1'b0};
    bit          eill[3]  = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive_op(1'b0, sts[i], fns[i], addrs[i], 64'($urandom), 64'($urandom), 0, 1'b0, o);
      checks++;
      if (o.done_cyc != 13) begin
        errors++; $display("FAIL fault%0d_latency got %0d want 13", i, o.done_cyc);
      end
      checks++;
      if (o.mis !== emis[i] || o.ill !== eill[i]) begin
        errors++; $display("FAIL fault%0d_flags got mis=%b ill=%b want mis=%b ill=%b",
                           i, o.mis, o.ill, emis[i], eill[i]);
      end
      checks++;
      if (o.we_cnt != 0) begin
        errors++; $display("FAIL fault%0d_no_write got %0d writes want 0", i, o.we_cnt);
      end
    end
  endtask

  task automatic test_wide_words();
    obs_t o;
    drive_op(1'b1, 1'b0, 3'b110, 12'd12, '0, 64'h8006_0000_0000_0000, 0, 1'b0, o);
    checks++;
    if (o.result !== 64'h0000_0000_8006_0000) begin
      errors++; $display("FAIL lwu64_result got %h want 0000000080060000", o.result);
    end
    checks++;
    if (o.done_cyc != 21 || o.maddr !== 12'd1) begin
      errors++; $display("FAIL lwu64_timing got done=%0d maddr=%0d want done=21 maddr=1", o.done_cyc, o.maddr);
    end
    drive_op(1'b1, 1'b0, 3'b010, 12'd12, '0, 64'h8006_0000_0000_0000, 0, 1'b0, o);
    checks++;
    if (o.result !== 64'hFFFF_FFFF_8006_0000) begin
      errors++; $display("FAIL lw64_result got %h want ffffffff80060000", o.result);
    end
  endtask

  // start held high throughout, including the DONE cycle: it must be ignored
  // while busy and in DONE, so the block is idle the cycle after done.
  task automatic test_back_to_back();
    obs_t o;
    logic [63:0] rd;
    for (int i = 0; i < 2; i++) begin
      rd = 64'($urandom);
      drive_op(1'b0, 1'b0, 3'b010, 12'(4 * i + 8), '0, rd, 0, 1'b1, o);
      checks++;
      if (o.result !== rd || o.done_cyc != 46) begin
        errors++; $display("FAIL b2b%0d_load got %h done=%0d want %h done=46", i, o.result, o.done_cyc, rd);
      end
      checks++;
      if (o.busy_after !== 1'b0) begin
        errors++; $display("FAIL b2b%0d_start_in_done got busy=%b want 0", i, o.busy_after);
      end
    end
  endtask

  task automatic test_reset_abort();
    obs_t o;
    logic [63:0] rd;
    drive_op(1'b0, 1'b1, 3'b010, 12'd8, 64'($urandom), '0, 22, 1'b0, o);
    checks++;
    if (o.busy_after !== 1'b0) begin
      errors++; $display("FAIL abort_busy got %b want 0", o.busy_after);
    end
    checks++;
    if (o.we_cnt != 0 || o.done_cyc != -1) begin
      errors++; $display("FAIL abort_quiet got writes=%0d done=%0d want writes=0 done=-1", o.we_cnt, o.done_cyc);
    end
    rd = 64'($urandom);
    drive_op(1'b0, 1'b0, 3'b010, 12'd4, '0, rd, 0, 1'b0, o);
    checks++;
    if (o.result !== rd || o.done_cyc != 46 || o.maddr !== 12'd1) begin
      errors++; $display("FAIL abort_recover got %h done=%0d maddr=%0d want %h done=46 maddr=1",
                         o.result, o.done_cyc, o.maddr, rd);
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit wide, st, e_ill, e_mis;
    int xlen, a_n, t_n, e_cyc;
    logic [2:0] fn;
    logic [11:0] addr;
    logic [63:0] sdata, rdata, e_res, e_wdata;
    logic [7:0] e_be;
    for (int n = 0; n < 40; n++) begin
      wide  = (n >= 26);
      xlen  = wide ? 64 : 32;
      a_n   = wide ? 3 : 12;
      t_n   = wide ? 16 : 32;
      st    = 1'($urandom);
      fn    = 3'($urandom);
      addr  = 12'($urandom);
      if ($urandom_range(0, 3) != 0) addr = addr & ~12'((1 << fn[1:0]) - 1);
      sdata = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      if (!wide) rdata[63:32] = '0;
      ref_fault(xlen, st, fn, addr, e_ill, e_mis);
      e_cyc = (e_ill || e_mis) ? a_n + 1 : (st ? a_n + t_n + 1 : a_n + t_n + 2);
      drive_op(wide, st, fn, addr, sdata, rdata, 0, 1'b0, o);
      checks++;
      if (o.done_cyc != e_cyc) begin
        errors++; $display("FAIL rnd%0d_latency got %0d want %0d", n, o.done_cyc, e_cyc);
      end
      checks++;
      if (o.ill !== e_ill || o.mis !== e_mis) begin
        errors++; $display("FAIL rnd%0d_flags got ill=%b mis=%b want ill=%b mis=%b", n, o.ill, o.mis, e_ill, e_mis);
      end
      checks++;
      if (o.stray != 0 || o.busy_after !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_idle got stray=%0d busy=%b want 0 0", n, o.stray, o.busy_after);
      end
      if (e_ill || e_mis) begin
        checks++;
        if (o.we_cnt != 0) begin
          errors++; $display("FAIL rnd%0d_fault_write got %0d want 0", n, o.we_cnt);
        end
      end else begin
        checks++;
        if (o.maddr !== 12'(int'(addr) / (xlen / 8))) begin
          errors++; $display("FAIL rnd%0d_mem_addr got %0d want %0d", n, o.maddr, int'(addr) / (xlen / 8));
        end
        if (st) begin
          ref_store(xlen, fn, addr, sdata, e_wdata, e_be);
          checks++;
          if (o.we_cnt != 1 || o.we_cyc != e_cyc || o.wdata !== e_wdata || o.be !== e_be) begin
            errors++; $display("FAIL rnd%0d_store got n=%0d c=%0d %h be=%b want n=1 c=%0d %h be=%b",
                               n, o.we_cnt, o.we_cyc, o.wdata, o.be, e_cyc, e_wdata, e_be);
          end
        end else begin
          e_res = ref_load(xlen, fn, addr, rdata);
          checks++;
          if (o.result !== e_res || o.we_cnt != 0) begin
            errors++; $display("FAIL rnd%0d_load got %h writes=%0d want %h writes=0", n, o.result, o.we_cnt, e_res);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb_lanes();
    test_unsigned_loads();
    test_store_byte();
    test_faults();
    test_wide_words();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
